// File: rtl/result_display_sequencer.sv
// Buffers depth_p results from the systolic array, then shows them one by one on data_o,
// each for hold_cycles_p clocks (skip_i advances early), pulsing done_o after the last one.
module result_display_sequencer #(
    parameter int width_p       = 8,
    parameter int depth_p       = 4,
    parameter int hold_cycles_p = 60000000
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         data_i,
    input  logic                       skip_i,
    input  logic                       flush_i,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(depth_p)-1:0] index_o,
    output logic                       displaying_o,
    output logic                       done_o,
    output logic                       state_o
);

    localparam int idx_w = $clog2(depth_p);
    localparam int cnt_w = $clog2(hold_cycles_p + 1);
    localparam logic [idx_w-1:0] last_slot = idx_w'(depth_p - 1);
    localparam logic [cnt_w-1:0] hold_last = cnt_w'(hold_cycles_p - 1);

    typedef enum logic {
        st_fill = 1'b0,
        st_show = 1'b1
    } state_e;

    state_e               state_q, state_n;
    logic [idx_w-1:0]     wr_cnt_q, wr_cnt_n;
    logic [idx_w-1:0]     idx_q, idx_n;
    logic [cnt_w-1:0]     cnt_q, cnt_n;
    logic                 done_q, done_n;
    logic                 wr_en;
    logic [width_p-1:0]   mem_q [depth_p];

    // Handshake: a result moves when valid_i and ready_o are both high at a rising edge;
    // ready_o depends only on state, and a flush cycle never moves data.
    always_comb begin
        state_n  = state_q;
        wr_cnt_n = wr_cnt_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        done_n   = 1'b0;
        wr_en    = 1'b0;
        if (flush_i) begin
            state_n  = st_fill;
            wr_cnt_n = '0;
            idx_n    = '0;
            cnt_n    = '0;
        end else begin
            case (state_q)
                st_fill: begin
                    if (valid_i) begin
                        wr_en = 1'b1;
                        if (wr_cnt_q == last_slot) begin
                            state_n  = st_show;
                            wr_cnt_n = '0;
                            idx_n    = '0;
                            cnt_n    = '0;
                        end else begin
                            wr_cnt_n = wr_cnt_q + 1'b1;
                        end
                    end
                end
                st_show: begin
                    // Skip and expiry in the same cycle collapse into one advance.
                    if (cnt_q == hold_last || skip_i) begin
                        cnt_n = '0;
                        if (idx_q == last_slot) begin
                            state_n  = st_fill;
                            idx_n    = '0;
                            wr_cnt_n = '0;
                            done_n   = 1'b1;
                        end else begin
                            idx_n = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_n = st_fill;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= st_fill;
            wr_cnt_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            wr_cnt_q <= wr_cnt_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            done_q   <= done_n;
        end
    end

    // Storage is not reset; stale contents are never shown because SHOW follows a full fill.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_cnt_q] <= data_i;
        end
    end

    assign ready_o      = (state_q == st_fill);
    assign displaying_o = (state_q == st_show);
    assign data_o       = (state_q == st_show) ? mem_q[idx_q] : '0;
    assign index_o      = idx_q;
    assign done_o       = done_q;
    assign state_o      = state_q;

endmodule
